arb_resource_resp: RTL and testbench
====================================

// Module: arb_resource_resp
// PURPOSE
//   Resource-side responder for the N-way request arbiter. Sees the arbiter's merged request
//   (req) and answers with the shared ack that the arbiter gates into its per-requester grants.
//   Samples the resulting one-hot grant vector, latches the owner and holds the resource busy
//   for a fixed service time. Flags protocol errors and optionally keeps per-requester grant counts.
// PARAMETERS
//   N           4  number of requesters; width of grant_vec and owner
//   SVC_CYCLES  3  busy cycles per granted transaction; legal range 1..255
//   CNT_W       8  width of each per-requester grant counter
// PORTS
//   clk        in   1       single clock; all logic on posedge
//   rst        in   1       synchronous reset, active-high
//   req        in   1       OR of all requests, from the arbiter's req_o
//   ack        out  1       shared acknowledge, to the arbiter's ack_o
//   grant_vec  in   N       arbiter per-requester ack_i (expected one-hot while ack=1)
//   owner      out  N       latched one-hot winner; 0 when no owner
//   busy       out  1       resource in service
//   done       out  1       1-cycle pulse at end of service
//   err_multi  out  1       sticky: grant_vec had >1 bit set during ACK
//   cnt_sel    in   $clog2(N)  counter read select
//   cnt_out    out  CNT_W   grant count of requester cnt_sel (combinational read)
// BEHAVIOUR
//   Reset: state=IDLE; ack=0, owner=0, busy=0, done=0, err_multi=0, timer=0, all counters=0.
//     Reset wins over every other event, including mid-ACK and mid-SERVE; no done is emitted.
//   Outputs ack, busy, done, owner are registered/state-decoded; no comb path from req to ack.
//   FSM (2-bit): IDLE, ACK, SERVE, DONE.
//   - IDLE: ack=0. req=1 -> ACK. req=0 -> IDLE.
//   - ACK: ack=1 for exactly one cycle. grant_vec sampled at the end of this cycle:
//       exactly one bit set -> owner<=grant_vec; count of that index +1; timer<=SVC_CYCLES-1; -> SERVE.
//       zero bits (req withdrawn) -> IDLE; owner stays 0; no count; not an error.
//       >1 bit set -> err_multi<=1; owner stays 0; no count; -> IDLE.
//   - SERVE: busy=1, ack=0. timer!=0 -> timer-1, stay. timer==0 -> DONE.
//       req/grant_vec are ignored in SERVE; new requests wait for IDLE.
//   - DONE: done=1 one cycle, busy=0; owner<=0; -> IDLE unconditionally.
//   Timing, req high from cycle t with FSM in IDLE: ack at t+1; busy t+2..t+1+SVC_CYCLES;
//     done at t+2+SVC_CYCLES; next ack no earlier than t+4+SVC_CYCLES (one IDLE cycle minimum).
//   err_multi clears only on rst.
//   Counters: saturate at 2^CNT_W-1 (no wrap). cnt_sel >= N reads 0.
// CONFIGURATION
//   Macro ARB_RESP_CNT_EN:
//   - defined: N counters of CNT_W bits implemented as above; cnt_out = count[cnt_sel].
//   - undefined: no counter storage is built; cnt_out tied to 0; cnt_sel ignored;
//       FSM, ack, owner, busy, done and err_multi timing are identical.
// TESTING (N=4, SVC_CYCLES=3, CNT_W=8)
//   1. req=1 from t=0, grant_vec=4'b0100 while ack=1 -> ack@1, owner=0100 and busy@2..4,
//      done@5, owner=0@6; with ARB_RESP_CNT_EN defined, cnt_sel=2 -> cnt_out=1.
//   2. req=1 held continuously, grant_vec one-hot -> ack pulses at 1, 7, 13 (period 6);
//      busy never overlaps ack.
//   3. ACK cycle with grant_vec=4'b0000 -> back to IDLE, owner=0, no count, err_multi=0.
//   4. ACK cycle with grant_vec=4'b0110 -> err_multi=1 (stays 1), owner=0, no count;
//      next clean grant is served normally.
//   5. 300 grants to requester 0 -> cnt_out (cnt_sel=0) saturates at 255; cnt_sel=1 reads 0.
//   6. rst=1 during SERVE (busy=1) -> next cycle all outputs 0, no done pulse, counters=0.

Source files
------------

// File: rtl/arb_resource_resp.sv
// arb_resource_resp: resource-side ack/serve responder for the N-way arbiter.
// Define ARB_RESP_CNT_EN to build the saturating per-requester grant counters.
module arb_resource_resp #(
  parameter int N = 4,
  parameter int SVC_CYCLES = 3,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  output logic                 ack,
  input  logic [N-1:0]         grant_vec,
  output logic [N-1:0]         owner,
  output logic                 busy,
  output logic                 done,
  output logic                 err_multi,
  input  logic [$clog2(N)-1:0] cnt_sel,
  output logic [CNT_W-1:0]     cnt_out
);
  localparam logic [1:0] IDLE = 2'd0, ACK = 2'd1, SERVE = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [7:0] timer;
  logic one_hot, multi;
  assign one_hot = grant_vec != '0 && (grant_vec & (grant_vec - 1'b1)) == '0;
  assign multi = grant_vec != '0 && !one_hot;
  assign ack = state == ACK;
  assign busy = state == SERVE;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      timer <= '0;
      err_multi <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= req ? ACK : IDLE;
        ACK: begin
          state <= one_hot ? SERVE : IDLE;
          owner <= one_hot ? grant_vec : '0;
          timer <= 8'(SVC_CYCLES - 1);
          err_multi <= err_multi | multi;
        end
        SERVE: begin
          state <= timer == '0 ? DONE : SERVE;
          timer <= timer == '0 ? timer : timer - 1'b1;
        end
        default: begin
          state <= IDLE;
          owner <= '0;
        end
      endcase
    end
  end
`ifdef ARB_RESP_CNT_EN
  logic [CNT_W-1:0] cnt [N];
  always_ff @(posedge clk)
    for (int i = 0; i < N; i++)
      if (rst) cnt[i] <= '0;
      else if (ack && one_hot && grant_vec[i] && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
  assign cnt_out = 32'(cnt_sel) < N ? cnt[cnt_sel] : '0;
`else
  logic unused_cnt_sel;
  assign unused_cnt_sel = ^cnt_sel;
  assign cnt_out = '0;
`endif
endmodule

// File: tb/tb_arb_resource_resp.sv
// tb_arb_resource_resp: directed plus randomized checks of arb_resource_resp against a
// transaction-timing model (ack cycle, service window, done cycle derived from ack time).
module tb_arb_resource_resp;
  localparam int N = 4, SVC = 3, CW = 8;
  logic clk = 0, rst = 1, req = 0;
  logic [N-1:0] grant_vec = '0, owner;
  logic ack, busy, done, err_multi;
  logic [1:0] cnt_sel = '0;
  logic [CW-1:0] cnt_out;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  arb_resource_resp #(.N(N), .SVC_CYCLES(SVC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .grant_vec(grant_vec), .owner(owner),
    .busy(busy), .done(done), .err_multi(err_multi), .cnt_sel(cnt_sel), .cnt_out(cnt_out)
  );
  // model: a transaction starts with its ack cycle; everything else is an offset from it
  int c = 0, ack_at = -100;
  bit in_txn = 0, accepted = 0, merr = 0, chk_en = 0;
  logic [N-1:0] mown = '0;
  int mcnt [N];
  logic e_ack, e_busy, e_done;
  logic [N-1:0] e_owner;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (model cycle %0d)", name, act, exp, c);
    end
  endtask
  task automatic model_step();
    bit was;
    int d;
    if (rst) begin
      in_txn = 0;
      merr = 0;
      for (int i = 0; i < N; i++) mcnt[i] = 0;
    end else begin
      was = in_txn;
      if (in_txn && c == ack_at) begin
        accepted = $countones(grant_vec) == 1;
        if ($countones(grant_vec) > 1) merr = 1;
        if (accepted) begin
          mown = grant_vec;
          for (int i = 0; i < N; i++)
            if (grant_vec[i] && mcnt[i] < (1 << CW) - 1) mcnt[i]++;
        end
      end
      if (!was && req) begin
        in_txn = 1;
        ack_at = c + 1;
        accepted = 0;
      end
    end
    c++;
    if (in_txn && c - ack_at >= (accepted ? SVC + 2 : 1)) in_txn = 0;
    d = c - ack_at;
    e_ack = in_txn && d == 0;
    e_busy = in_txn && accepted && d >= 1 && d <= SVC;
    e_done = in_txn && accepted && d == SVC + 1;
    e_owner = (in_txn && accepted && d >= 1) ? mown : '0;
  endtask
  function automatic logic [CW-1:0] e_cnt();
`ifdef ARB_RESP_CNT_EN
    return CW'(mcnt[cnt_sel]);
`else
    return '0;
`endif
  endfunction
  always @(negedge clk) if (chk_en) begin
    chk("ack", 32'(ack), 32'(e_ack));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    chk("owner", 32'(owner), 32'(e_owner));
    chk("err_multi", 32'(err_multi), 32'(merr));
    chk("cnt_out", 32'(cnt_out), 32'(e_cnt()));
  end
  task automatic cycle(input logic r, input logic [N-1:0] g, input logic rs, input logic [1:0] sel);
    @(posedge clk);
    #1;
    model_step();
    chk_en = 1;
    req = r;
    grant_vec = g;
    rst = rs;
    cnt_sel = sel;
  endtask
`ifdef ARB_RESP_CNT_EN
  localparam int EN = 1;
`else
  localparam int EN = 0;
`endif
  initial begin
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 2);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err_multi), 0);
    // single grant to requester 2
    cycle(1, 4'b0100, 0, 2);
    chk("t0_ack", 32'(ack), 0);
    cycle(1, 4'b0100, 0, 2);
    chk("t1_ack", 32'(ack), 1);
    cycle(0, 4'b0100, 0, 2);
    chk("t2_owner", 32'(owner), 32'h4);
    chk("t2_busy", 32'(busy), 1);
    cycle(0, 0, 0, 2);
    cycle(0, 0, 0, 2);
    chk("t4_busy", 32'(busy), 1);
    cycle(0, 0, 0, 2);
    chk("t5_done", 32'(done), 1);
    chk("t5_busy", 32'(busy), 0);
    cycle(0, 0, 0, 2);
    chk("t6_owner", 32'(owner), 0);
    chk("t6_done", 32'(done), 0);
    chk("t6_cnt2", 32'(cnt_out), 32'(EN));
    // back-to-back with req held: ack period 6
    for (int k = 0; k < 14; k++) begin
      cycle(1, 4'b0001, 0, 0);
      if (k == 1 || k == 7 || k == 13) chk("held_ack", 32'(ack), 1);
      if (k == 0 || k == 6 || k == 12) chk("held_noack", 32'(ack), 0);
    end
    for (int k = 0; k < 6; k++) cycle(0, 0, 0, 0);
    // withdrawn request
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("wd_ack", 32'(ack), 1);
    cycle(0, 0, 0, 0);
    chk("wd_owner", 32'(owner), 0);
    chk("wd_busy", 32'(busy), 0);
    chk("wd_err", 32'(err_multi), 0);
    // multi-bit grant, then a clean one
    cycle(1, 4'b0110, 0, 1);
    cycle(0, 4'b0110, 0, 1);
    cycle(0, 0, 0, 1);
    chk("mb_err", 32'(err_multi), 1);
    chk("mb_owner", 32'(owner), 0);
    chk("mb_cnt1", 32'(cnt_out), 0);
    cycle(1, 4'b1000, 0, 3);
    cycle(0, 4'b1000, 0, 3);
    cycle(0, 0, 0, 3);
    chk("clean_owner", 32'(owner), 32'h8);
    chk("clean_err", 32'(err_multi), 1);
    for (int k = 0; k < 5; k++) cycle(0, 0, 0, 3);
    // saturation on requester 0
    for (int k = 0; k < 1800; k++) cycle(1, 4'b0001, 0, 0);
    for (int k = 0; k < 6; k++) cycle(0, 0, 0, 0);
    chk("sat_cnt0", 32'(cnt_out), 32'(EN * 255));
    cycle(0, 0, 0, 1);
    chk("sat_cnt1", 32'(cnt_out), 0);
    // reset during service
    cycle(1, 4'b0010, 0, 0);
    cycle(0, 4'b0010, 0, 0);
    cycle(0, 0, 0, 0);
    chk("pre_rst_busy", 32'(busy), 1);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_owner", 32'(owner), 0);
    chk("post_rst_err", 32'(err_multi), 0);
    chk("post_rst_cnt0", 32'(cnt_out), 0);
    cycle(0, 0, 0, 0);
    chk("post_rst_done", 32'(done), 0);
    // randomized traffic
    for (int k = 0; k < 4000; k++) begin
      logic [N-1:0] g;
      int p = $urandom_range(0, 99);
      g = p < 60 ? N'(1 << $urandom_range(0, N - 1)) : p < 80 ? '0 : N'($urandom);
      cycle($urandom_range(0, 9) < 7, g, $urandom_range(0, 99) == 0, 2'($urandom_range(0, 3)));
    end
    cycle(0, 0, 0, 0);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
